reg_wr_arbiter: RTL and testbench
=================================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the register, 2..8.
REQ-002 Parameter W, default 8: data width of the shared register.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive locked grant cycles, 1..15.
REQ-004 clk  input  1: single clock; all state changes on the posedge.
REQ-005 res  input  1: synchronous, active-high reset, sampled on the clk posedge.
REQ-006 req  input  N: per-requester write request, level; held until the matching gnt is seen.
REQ-007 lock  input  N: per-requester burst hold, sampled only while that requester is granted.
REQ-008 wdata  input  N*W: requester i data in bits [i*W+W-1 : i*W].
REQ-009 gnt  output  N: registered one-hot grant; at most one bit set.
REQ-010 q  output  W: shared register contents, registered.
REQ-011 q_vld  output  1: one-cycle pulse in the cycle after q is updated.
REQ-012 busy  output  1: high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-014 IDLE with req==0 SHALL stay in IDLE with gnt==0.
REQ-015 IDLE with req!=0 at edge t SHALL enter GRANT and set gnt one-hot from edge t, so gnt is visible in the following cycle.
REQ-016 Winner selection SHALL be round-robin: search from index ptr+1 upward, wrapping from N-1 to 0; the first set req bit wins.
REQ-017 ptr SHALL be loaded with the winner index on each grant, and reset to N-1 so index 0 wins first.
REQ-018 In GRANT, the edge ending the cycle SHALL load q with the granted slice of wdata, and q_vld SHALL be high in the next cycle.
REQ-019 GRANT SHALL return to IDLE after one cycle unless extended per REQ-023; gnt SHALL clear on that edge.
REQ-020 One IDLE cycle SHALL separate consecutive grants, so unlocked throughput is 1 write per 2 cycles.
REQ-021 req from the granted requester sampled in the IDLE recovery cycle SHALL be treated as a new request.
REQ-022 req bits of non-granted requesters SHALL be ignored during GRANT; their requests remain pending.
REQ-023 With the lock feature enabled, if lock[g] and req[g] are high for granted index g, the block SHALL stay in GRANT and write q on every cycle.
REQ-024 A 4-bit burst counter SHALL count GRANT cycles; when it reaches MAX_BURST, the block SHALL return to IDLE regardless of lock.
REQ-025 The burst counter SHALL clear on entry to GRANT.
REQ-026 After a forced release, ptr SHALL advance normally so other pending requesters win next.

Reset
REQ-027 On res==1 at a posedge, state SHALL become IDLE, and gnt, q, q_vld, busy and the burst counter SHALL become 0, with ptr=N-1.
REQ-028 Reset during GRANT SHALL drop gnt at that edge with no q write.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 The macro REG_WR_ARB_LOCK_EN defined SHALL enable REQ-023 to REQ-026.
REQ-031 Without REG_WR_ARB_LOCK_EN, the lock port SHALL remain but be ignored; every GRANT lasts exactly one cycle and the burst counter SHALL not exist.

Verification
REQ-032 Single request (N=4, W=8): req=0001 and wdata[7:0]=0xA5 at cycle 1 -> gnt=0001 in cycle 2, q=0xA5 with q_vld=1 in cycle 3, then busy=0.
REQ-033 Round-robin wrap: all req bits held high -> grant order is 0,1,2,3,0, with gnt in every second cycle.
REQ-034 Locked burst (macro on, MAX_BURST=4): lock[2]=1 with req[2]=1 held -> gnt=0100 for exactly 4 cycles, q follows wdata each cycle, then IDLE, and pending req[0] is granted next.
REQ-035 Lock with the macro off: same stimulus as REQ-034 -> a 1-cycle gnt only, and requester 2 re-arbitrates after the IDLE gap.
REQ-036 Reset mid-operation: res=1 in the GRANT cycle for requester 1 -> next cycle gnt=0, q=0, q_vld=0, and the first grant after reset goes to index 0 when req=1111.
REQ-037 Simultaneous events: a new req[3] arrives during requester 1's GRANT -> it is not granted in that cycle and is granted after the IDLE cycle.

Source files
------------

// File: rtl/reg_wr_arbiter_if.sv
// Bus bundle between requesters (master side) and the shared-register write arbiter (slave side).
interface reg_wr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_vld;
  logic           busy;

  modport master (output req, lock, wdata, input gnt, q, q_vld, busy);
  modport slave  (input req, lock, wdata, output gnt, q, q_vld, busy);
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter for one shared register; IDLE/GRANT FSM with registered outputs.
// Define REG_WR_ARB_LOCK_EN to enable locked bursts of up to MAX_BURST grant cycles.
module reg_wr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              res,
  reg_wr_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] PTR_RST = PW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1'b1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   q_q, q_d;
  logic           q_vld_q, q_vld_d;
  logic           busy_q, busy_d;

  logic           win_vld;
  logic [PW-1:0]  win_idx;
  logic           stay;

  // Round-robin search starting one above ptr and wrapping; returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic          found;
    logic          take;
    logic [PW-1:0] idx;
    logic [PW:0]   cand;
    found = 1'b0;
    idx   = p;
    for (int off = 1; off <= N; off++) begin
      cand  = {1'b0, p} + (PW+1)'(off);
      cand  = (cand >= (PW+1)'(N)) ? cand - (PW+1)'(N) : cand;
      take  = !found && r[cand[PW-1:0]];
      idx   = take ? cand[PW-1:0] : idx;
      found = found | take;
    end
    return {found, idx};
  endfunction

  assign {win_vld, win_idx} = rr_pick(bus.req, ptr_q);

`ifdef REG_WR_ARB_LOCK_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [3:0] burst_q, burst_d;

  // Burst length tracking: counter is held at zero in IDLE, so it starts clear on every grant entry.
  always_comb begin
    burst_d = burst_q;
    stay    = 1'b0;
    if (state_q == GRANT) begin
      stay    = bus.lock[ptr_q] & bus.req[ptr_q] & ((burst_q + 4'd1) < BURST_MAX);
      burst_d = stay ? (burst_q + 4'd1) : 4'd0;
    end else begin
      burst_d = 4'd0;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (res) begin
      burst_q <= 4'd0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^{bus.lock, 4'(MAX_BURST)};
  assign stay        = 1'b0;
`endif

  // Next-state and output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    q_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          ptr_d   = win_idx;
          gnt_d   = ONE_HOT0 << win_idx;
        end else begin
          state_d = IDLE;
          gnt_d   = {N{1'b0}};
        end
      end
      GRANT: begin
        // The granted requester's data lands in q on the edge that ends each grant cycle.
        q_d     = bus.wdata[int'(ptr_q)*W +: W];
        q_vld_d = 1'b1;
        if (stay) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
          gnt_d   = {N{1'b0}};
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N{1'b0}};
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset overrides everything, including a pending q write.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= {N{1'b0}};
      q_q     <= {W{1'b0}};
      q_vld_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.q     = q_q;
  assign bus.q_vld = q_vld_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_reg_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_wr_arbiter_if #(.N(N), .W(W)) bus ();

  reg_wr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: owner is the granted requester, -1 when nobody holds the register.
  int         m_owner = -1;
  int         m_ptr   = N - 1;
  int         m_burst = 0;
  logic [7:0] m_q     = 8'h00;
  logic       m_qv    = 1'b0;

  function automatic int rr(input logic [3:0] r, input int p);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (p + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (res) begin
      m_owner = -1; m_ptr = N - 1; m_burst = 0; m_q = 8'h00; m_qv = 1'b0;
    end else if (m_owner < 0) begin
      m_qv = 1'b0;
      w = rr(bus.req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_burst = 1;
      end
    end else begin
      m_q  = bus.wdata[m_owner*W +: W];
      m_qv = 1'b1;
`ifdef REG_WR_ARB_LOCK_EN
      if (bus.lock[m_owner[1:0]] && bus.req[m_owner[1:0]] && m_burst < MB) m_burst++;
      else m_owner = -1;
`else
      m_owner = -1;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("model_gnt",   32'(bus.gnt),   32'(eg));
    chk("model_q",     32'(bus.q),     32'(m_q));
    chk("model_q_vld", 32'(bus.q_vld), 32'(m_qv));
    chk("model_busy",  32'(bus.busy),  32'(m_owner >= 0));
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] eg;
    bus.req = 4'b0000; bus.lock = 4'b0000; bus.wdata = 32'h0000_0000;

    // Reset state
    tick(); tick();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_q_vld", 32'(bus.q_vld), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // Single request
    res = 1'b0; bus.req = 4'b0001; bus.wdata = 32'h0000_00A5;
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    chk("single_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b0000;
    tick();
    chk("single_q", 32'(bus.q), 32'hA5);
    chk("single_q_vld", 32'(bus.q_vld), 32'h1);
    chk("single_busy_end", 32'(bus.busy), 32'h0);
    tick();
    chk("single_q_vld_pulse", 32'(bus.q_vld), 32'h0);

    // Round-robin wrap with all requests held
    res = 1'b1; tick(); res = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      eg = (k % 2 == 0) ? 4'(1 << ((k / 2) % N)) : 4'b0000;
      chk("rr_order", 32'(bus.gnt), 32'(eg));
    end
    bus.req = 4'b0000; tick(); tick();

    // Lock on requester 2 with requester 0 pending
    res = 1'b1; tick(); res = 1'b0;
    bus.req = 4'b0100; bus.lock = 4'b0100; bus.wdata = $urandom;
    tick();
    chk("lock_first_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0101;
`ifdef REG_WR_ARB_LOCK_EN
    for (int c = 0; c < MB - 1; c++) begin
      d = 8'($urandom); bus.wdata[23:16] = d;
      tick();
      chk("lock_hold_gnt", 32'(bus.gnt), 32'h4);
      chk("lock_q_follow", 32'(bus.q), 32'(d));
    end
    d = 8'($urandom); bus.wdata[23:16] = d;
    tick();
    chk("lock_release_gnt", 32'(bus.gnt), 32'h0);
    chk("lock_last_q", 32'(bus.q), 32'(d));
    tick();
    chk("lock_next_winner", 32'(bus.gnt), 32'h1);
`else
    d = 8'($urandom); bus.wdata[23:16] = d;
    tick();
    chk("nolock_release", 32'(bus.gnt), 32'h0);
    chk("nolock_q", 32'(bus.q), 32'(d));
    tick();
    chk("nolock_next_winner", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0100;
    tick();
    chk("nolock_gap", 32'(bus.gnt), 32'h0);
    tick();
    chk("nolock_rearb", 32'(bus.gnt), 32'h4);
`endif
    bus.req = 4'b0000; bus.lock = 4'b0000; tick(); tick();

    // Held request re-arbitrates after the idle cycle, then reset hits the grant cycle
    bus.req = 4'b0010; bus.wdata = 32'h5A5A_5A5A;
    tick();
    chk("rearm_gnt1", 32'(bus.gnt), 32'h2);
    tick();
    chk("rearm_q", 32'(bus.q), 32'h5A);
    tick();
    chk("rearm_gnt2", 32'(bus.gnt), 32'h2);
    res = 1'b1; bus.req = 4'b1111;
    tick();
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    chk("midrst_q", 32'(bus.q), 32'h0);
    chk("midrst_q_vld", 32'(bus.q_vld), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    res = 1'b0;
    tick();
    chk("midrst_first", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000; tick(); tick();

    // New request arriving during another requester's grant
    bus.req = 4'b0010;
    tick();
    chk("late_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1010;
    tick();
    chk("late_not_granted", 32'(bus.gnt), 32'h0);
    bus.req = 4'b1000;
    tick();
    chk("late_granted", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000; tick(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      res       = ($urandom_range(0, 39) == 0);
      bus.req   = 4'($urandom);
      bus.lock  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus.wdata = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
